// File: rtl/drfa_pkg.sv
// -----------------------------------------------------------------------------
// drfa_pkg
// Shared definitions for the memory-access sequencer used by the control unit
// for the `write` instruction family ([addr] <= R0).
//   - Default widths for the data bus, the immediate address and the register
//     selector
//   - Addressing-mode encodings, as decoded from the IR
//   - Sequencer state enumeration
//   - Index of R0, the fixed source (store) / destination (load) register
// Optional feature macro: MEM_ACCESS_SEQ_LOAD_EN (see mem_access_sequencer.sv).
// -----------------------------------------------------------------------------
package drfa_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int SEL_W_DEF  = 3;

  // R0 is always the data register of the transfer.
  localparam int R0_IDX = 0;

  typedef enum logic [1:0] {
    MODE_IMM     = 2'd0,
    MODE_MEM_IND = 2'd1,
    MODE_REG     = 2'd2,
    MODE_REG_IND = 2'd3
  } mode_t;

  // Eight states fill the 3-bit encoding exactly. The FSM and the output
  // decoder still carry default branches (next state IDLE, all outputs low),
  // so widening the enum later cannot create a stuck state.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR_IMM  = 3'd1,
    ST_DEREF_MEM = 3'd2,
    ST_ADDR_REG  = 3'd3,
    ST_LATCH_PTR = 3'd4,
    ST_ADDR_PTR  = 3'd5,
    ST_STORE     = 3'd6,
    ST_DONE      = 3'd7
  } state_t;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer_if
// Groups the control-unit handshake and the shared-bus control signals of the
// memory-access sequencer.
// Signals:
//   start, mode, imm, ry        request from the CU FSM (start sampled in IDLE)
//   rout_low                    low SEL_W bits of the register-file output
//   busy, done                  status (busy = not IDLE, done = 1-cycle pulse)
//   reg_ry_sel, reg_read_en     register-file read port, which drives the bus
//   cu_out_en, cu_out_data      the CU drives the zero-extended immediate
//   mar_write_en                MAR loads the bus
//   mem_read_en, mem_write_en   data memory drives / writes the bus at MAR
//   dir, reg_rx_sel, reg_write_en   only with MEM_ACCESS_SEQ_LOAD_EN
// Modports: master = CU / datapath side, slave = sequencer.
// -----------------------------------------------------------------------------
interface mem_access_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 3
);

  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] imm;
  logic [SEL_W-1:0]  ry;
  logic [SEL_W-1:0]  rout_low;

  logic              busy;
  logic              done;
  logic [SEL_W-1:0]  reg_ry_sel;
  logic              reg_read_en;
  logic              cu_out_en;
  logic [DATA_W-1:0] cu_out_data;
  logic              mar_write_en;
  logic              mem_read_en;
  logic              mem_write_en;

`ifdef MEM_ACCESS_SEQ_LOAD_EN
  logic              dir;
  logic [SEL_W-1:0]  reg_rx_sel;
  logic              reg_write_en;
`endif

  modport master (
    output start, mode, imm, ry, rout_low,
`ifdef MEM_ACCESS_SEQ_LOAD_EN
    output dir,
    input  reg_rx_sel, reg_write_en,
`endif
    input  busy, done, reg_ry_sel, reg_read_en, cu_out_en, cu_out_data,
    input  mar_write_en, mem_read_en, mem_write_en
  );

  modport slave (
    input  start, mode, imm, ry, rout_low,
`ifdef MEM_ACCESS_SEQ_LOAD_EN
    input  dir,
    output reg_rx_sel, reg_write_en,
`endif
    output busy, done, reg_ry_sel, reg_read_en, cu_out_en, cu_out_data,
    output mar_write_en, mem_read_en, mem_write_en
  );

endinterface

// File: rtl/mem_access_out_decode.sv
// -----------------------------------------------------------------------------
// mem_access_out_decode
// Moore output decoder of the memory-access sequencer: turns the registered
// state plus the captured request fields into bus enables and selectors.
// Purely combinational; since every input is a register, the outputs change
// only after a clock edge or an asynchronous reset.
// Ports:
//   i_state          current sequencer state
//   i_imm            captured address immediate
//   i_ry             captured source-register field
//   i_ptr            register index latched in LATCH_PTR
//   i_dir            captured direction, 1 = load (MEM_ACCESS_SEQ_LOAD_EN only)
//   o_*              the status and bus-control outputs of the sequencer
// Optional feature macro: MEM_ACCESS_SEQ_LOAD_EN.
// -----------------------------------------------------------------------------
module mem_access_out_decode
  import drfa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  state_t            i_state,
  input  logic [ADDR_W-1:0] i_imm,
  input  logic [SEL_W-1:0]  i_ry,
  input  logic [SEL_W-1:0]  i_ptr,
`ifdef MEM_ACCESS_SEQ_LOAD_EN
  input  logic              i_dir,
  output logic [SEL_W-1:0]  o_reg_rx_sel,
  output logic              o_reg_write_en,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic [SEL_W-1:0]  o_reg_ry_sel,
  output logic              o_reg_read_en,
  output logic              o_cu_out_en,
  output logic [DATA_W-1:0] o_cu_out_data,
  output logic              o_mar_write_en,
  output logic              o_mem_read_en,
  output logic              o_mem_write_en
);

  localparam logic [SEL_W-1:0] R0_SEL = SEL_W'(R0_IDX);

  always_comb begin
    o_busy         = 1'b0;
    o_done         = 1'b0;
    o_reg_ry_sel   = '0;
    o_reg_read_en  = 1'b0;
    o_cu_out_en    = 1'b0;
    o_cu_out_data  = '0;
    o_mar_write_en = 1'b0;
    o_mem_read_en  = 1'b0;
    o_mem_write_en = 1'b0;
`ifdef MEM_ACCESS_SEQ_LOAD_EN
    o_reg_rx_sel   = '0;
    o_reg_write_en = 1'b0;
`endif

    case (i_state)
      ST_IDLE: begin
      end

      // MAR <= zero-extended immediate. The upper bits stay at their zero
      // default, and the data is non-zero only while cu_out_en is high.
      ST_ADDR_IMM: begin
        o_busy                     = 1'b1;
        o_cu_out_en                = 1'b1;
        o_cu_out_data[ADDR_W-1:0]  = i_imm;
        o_mar_write_en             = 1'b1;
      end

      // MAR <= mem[MAR]: memory drives the bus while MAR reloads from it.
      ST_DEREF_MEM: begin
        o_busy         = 1'b1;
        o_mem_read_en  = 1'b1;
        o_mar_write_en = 1'b1;
      end

      ST_ADDR_REG: begin
        o_busy         = 1'b1;
        o_reg_ry_sel   = i_ry;
        o_reg_read_en  = 1'b1;
        o_mar_write_en = 1'b1;
      end

      // Ry is put on the bus only so its low bits (rout_low) can be captured
      // as the pointer; MAR is not written here.
      ST_LATCH_PTR: begin
        o_busy        = 1'b1;
        o_reg_ry_sel  = i_ry;
        o_reg_read_en = 1'b1;
      end

      ST_ADDR_PTR: begin
        o_busy         = 1'b1;
        o_reg_ry_sel   = i_ptr;
        o_reg_read_en  = 1'b1;
        o_mar_write_en = 1'b1;
      end

      ST_STORE: begin
        o_busy = 1'b1;
`ifdef MEM_ACCESS_SEQ_LOAD_EN
        if (i_dir) begin
          // Load: memory drives the bus, R0 takes it.
          o_mem_read_en  = 1'b1;
          o_reg_rx_sel   = R0_SEL;
          o_reg_write_en = 1'b1;
        end else begin
          o_reg_ry_sel   = R0_SEL;
          o_reg_read_en  = 1'b1;
          o_mem_write_en = 1'b1;
        end
`else
        o_reg_ry_sel   = R0_SEL;
        o_reg_read_en  = 1'b1;
        o_mem_write_en = 1'b1;
`endif
      end

      ST_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end

      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// mem_access_sequencer
// Multi-cycle sequencer for the `write` instruction family ([addr] <= R0).
// It computes the target address into MAR through the shared bus using one of
// four addressing modes and then stores R0 at that address:
//   IMM      ADDR_IMM -> STORE -> DONE                    (done 3 cycles after accept)
//   MEM_IND  ADDR_IMM -> DEREF_MEM -> STORE -> DONE       (4 cycles)
//   REG      ADDR_REG -> STORE -> DONE                    (3 cycles)
//   REG_IND  LATCH_PTR -> ADDR_PTR -> STORE -> DONE       (4 cycles)
// start is sampled only in IDLE; a pulse while busy or in DONE is dropped and
// is not remembered. mode/imm/ry (and dir) are captured when the request is
// accepted. Reset is asynchronous and active-low; an operation in flight is
// abandoned without writing memory.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   bus     mem_access_sequencer_if.slave: request, status and bus controls
// Optional feature macro: MEM_ACCESS_SEQ_LOAD_EN adds a load direction
// (dir = 1: R0 <= [addr]) with the reg_rx_sel/reg_write_en outputs.
// -----------------------------------------------------------------------------
module mem_access_sequencer
  import drfa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  mem_access_sequencer_if.slave bus
);

  state_t            r_state;
  mode_t             r_mode;
  logic [ADDR_W-1:0] r_imm;
  logic [SEL_W-1:0]  r_ry;
  logic [SEL_W-1:0]  r_ptr;
`ifdef MEM_ACCESS_SEQ_LOAD_EN
  logic              r_dir;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_IMM;
      r_imm   <= '0;
      r_ry    <= '0;
      r_ptr   <= '0;
`ifdef MEM_ACCESS_SEQ_LOAD_EN
      r_dir   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_mode <= mode_t'(bus.mode);
            r_imm  <= bus.imm;
            r_ry   <= bus.ry;
`ifdef MEM_ACCESS_SEQ_LOAD_EN
            r_dir  <= bus.dir;
`endif
            case (mode_t'(bus.mode))
              MODE_IMM, MODE_MEM_IND: r_state <= ST_ADDR_IMM;
              MODE_REG:               r_state <= ST_ADDR_REG;
              MODE_REG_IND:           r_state <= ST_LATCH_PTR;
              default:                r_state <= ST_IDLE;
            endcase
          end
        end

        // Both immediate modes share the first address phase; memory-indirect
        // then dereferences once more through the memory.
        ST_ADDR_IMM:
          r_state <= (r_mode == MODE_MEM_IND) ? ST_DEREF_MEM : ST_STORE;

        ST_DEREF_MEM: r_state <= ST_STORE;
        ST_ADDR_REG:  r_state <= ST_STORE;

        // Ry is on the bus this cycle; its low bits name the register that
        // holds the final address.
        ST_LATCH_PTR: begin
          r_ptr   <= bus.rout_low;
          r_state <= ST_ADDR_PTR;
        end

        ST_ADDR_PTR: r_state <= ST_STORE;
        ST_STORE:    r_state <= ST_DONE;
        ST_DONE:     r_state <= ST_IDLE;
        default:     r_state <= ST_IDLE;
      endcase
    end
  end

  mem_access_out_decode #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W)
  ) u_out_decode (
    .i_state        (r_state),
    .i_imm          (r_imm),
    .i_ry           (r_ry),
    .i_ptr          (r_ptr),
`ifdef MEM_ACCESS_SEQ_LOAD_EN
    .i_dir          (r_dir),
    .o_reg_rx_sel   (bus.reg_rx_sel),
    .o_reg_write_en (bus.reg_write_en),
`endif
    .o_busy         (bus.busy),
    .o_done         (bus.done),
    .o_reg_ry_sel   (bus.reg_ry_sel),
    .o_reg_read_en  (bus.reg_read_en),
    .o_cu_out_en    (bus.cu_out_en),
    .o_cu_out_data  (bus.cu_out_data),
    .o_mar_write_en (bus.mar_write_en),
    .o_mem_read_en  (bus.mem_read_en),
    .o_mem_write_en (bus.mem_write_en)
  );

endmodule

// File: tb/tb_mem_access_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_access_sequencer
// Bench for mem_access_sequencer. A small datapath model (8 registers, 256-byte
// memory, MAR, shared bus) reacts to the sequencer's enables. Each scenario
// pushes its expected store (address, data, latency) to a scoreboard and pops
// it when done is seen. A background monitor checks the bus-driver and busy
// rules every clock.
// Optional feature macro: MEM_ACCESS_SEQ_LOAD_EN (adds a load scenario).
// -----------------------------------------------------------------------------
module tb_mem_access_sequencer;
  import drfa_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int SEL_W  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_access_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) ifc ();

  mem_access_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // ---------------- datapath model ----------------
  logic [7:0] regs [8];
  logic [7:0] mem  [256];
  logic [7:0] mar;
  logic [7:0] bus_val;
  int         n_writes = 0;
  logic [7:0] last_wr_addr = 8'h00;
  logic [7:0] last_wr_data = 8'h00;

  // Setup writes into the model go through this port, so the model arrays
  // have one writer.
  logic       set_en = 1'b0;
  logic       set_mem = 1'b0;
  logic [7:0] set_addr = 8'h00;
  logic [7:0] set_data = 8'h00;

  assign ifc.rout_low = regs[ifc.reg_ry_sel][SEL_W-1:0];

  always_comb begin
    bus_val = 8'h00;
    if (ifc.cu_out_en)        bus_val = ifc.cu_out_data;
    else if (ifc.reg_read_en) bus_val = regs[ifc.reg_ry_sel];
    else if (ifc.mem_read_en) bus_val = mem[mar];
  end

  always @(posedge clk) begin
    if (set_en) begin
      if (set_mem) mem[set_addr] <= set_data;
      else         regs[set_addr[2:0]] <= set_data;
    end
    if (ifc.mar_write_en) mar <= bus_val;
    if (ifc.mem_write_en) begin
      mem[mar]     <= bus_val;
      n_writes     <= n_writes + 1;
      last_wr_addr <= mar;
      last_wr_data <= bus_val;
    end
`ifdef MEM_ACCESS_SEQ_LOAD_EN
    if (ifc.reg_write_en) regs[ifc.reg_rx_sel] <= bus_val;
`endif
  end

  // ---------------- scoreboard / counters ----------------
  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         lat;
    string      name;
  } exp_t;

  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [17:0] out_vec();
    return {ifc.busy, ifc.done, ifc.reg_ry_sel, ifc.reg_read_en, ifc.cu_out_en,
            ifc.cu_out_data, ifc.mar_write_en, ifc.mem_read_en, ifc.mem_write_en};
  endfunction

  // Called at a negedge; the write lands on the following posedge.
  task automatic poke(input logic is_mem, input logic [7:0] a, input logic [7:0] d);
    set_mem  = is_mem;
    set_addr = a;
    set_data = d;
    set_en   = 1'b1;
    @(negedge clk);
    set_en   = 1'b0;
  endtask

  // Presents a one-cycle start; returns at the negedge of cycle 1 after accept.
  task automatic start_op(input logic [1:0] m, input logic [7:0] im, input logic [2:0] r);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.mode  = m;
    ifc.imm   = im;
    ifc.ry    = r;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (ifc.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if (out_vec() !== 18'h0) $display("FAIL reset_async: outputs=%05h want 00000", out_vec());
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (out_vec() !== 18'h0) $display("FAIL reset_idle: outputs=%05h want 00000", out_vec());
    else n_pass++;
  endtask

  task automatic test_imm();
    exp_t e;
    int lat;
    int wb;
    poke(1'b0, 8'd0, 8'h55);
    poke(1'b1, 8'h2A, 8'h00);
    sb.push_back('{addr: 8'h2A, data: 8'h55, lat: 3, name: "imm"});
    wb = n_writes;
    start_op(2'd0, 8'h2A, 3'd0);
    ifc.imm = 8'hFF;  // must be ignored after accept
    n_total++;
    if ({ifc.cu_out_en, ifc.mar_write_en, ifc.cu_out_data} !== {2'b11, 8'h2A})
      $display("FAIL imm_cycle1: en/mar/data=%b%b/%02h want 11/2a",
               ifc.cu_out_en, ifc.mar_write_en, ifc.cu_out_data);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({ifc.mem_write_en, ifc.reg_read_en, ifc.reg_ry_sel} !== {2'b11, 3'd0})
      $display("FAIL imm_cycle2: wr/rd/sel=%b%b/%0d want 11/0",
               ifc.mem_write_en, ifc.reg_read_en, ifc.reg_ry_sel);
    else n_pass++;
    wait_done(2, lat);
    n_total++;
    if (ifc.busy !== 1'b1) $display("FAIL imm_done_busy: busy=%b want 1", ifc.busy);
    else n_pass++;
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat) $display("FAIL %s_latency: got %0d want %0d", e.name, lat, e.lat);
    else n_pass++;
    n_total++;
    if ({last_wr_addr, last_wr_data} !== {e.addr, e.data})
      $display("FAIL %s_write: addr/data=%02h/%02h want %02h/%02h",
               e.name, last_wr_addr, last_wr_data, e.addr, e.data);
    else n_pass++;
    n_total++;
    if (n_writes - wb !== 1) $display("FAIL %s_write_count: got %0d want 1", e.name, n_writes - wb);
    else n_pass++;
    $display("txn %s addr=%02h data=%02h lat=%0d", e.name, last_wr_addr, last_wr_data, lat);
    @(negedge clk);
    n_total++;
    if ({ifc.busy, ifc.done} !== 2'b00) $display("FAIL imm_after_done: busy/done=%b%b want 00", ifc.busy, ifc.done);
    else n_pass++;
    ifc.imm = 8'h00;
  endtask

  task automatic test_mem_ind();
    exp_t e;
    int lat;
    int wb;
    poke(1'b1, 8'h10, 8'h80);
    poke(1'b0, 8'd0, 8'h11);
    poke(1'b1, 8'h80, 8'h00);
    sb.push_back('{addr: 8'h80, data: 8'h11, lat: 4, name: "mem_ind"});
    wb = n_writes;
    start_op(2'd1, 8'h10, 3'd0);
    n_total++;
    if (ifc.cu_out_data !== 8'h10) $display("FAIL mem_ind_cycle1: data=%02h want 10", ifc.cu_out_data);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({ifc.mem_read_en, ifc.mar_write_en, ifc.mem_write_en} !== 3'b110)
      $display("FAIL mem_ind_deref: rd/mar/wr=%b%b%b want 110",
               ifc.mem_read_en, ifc.mar_write_en, ifc.mem_write_en);
    else n_pass++;
    wait_done(2, lat);
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat) $display("FAIL %s_latency: got %0d want %0d", e.name, lat, e.lat);
    else n_pass++;
    n_total++;
    if ({last_wr_addr, last_wr_data, mem[e.addr]} !== {e.addr, e.data, e.data})
      $display("FAIL %s_write: addr/data=%02h/%02h want %02h/%02h",
               e.name, last_wr_addr, last_wr_data, e.addr, e.data);
    else n_pass++;
    n_total++;
    if (n_writes - wb !== 1) $display("FAIL %s_write_count: got %0d want 1", e.name, n_writes - wb);
    else n_pass++;
    $display("txn %s addr=%02h data=%02h lat=%0d", e.name, last_wr_addr, last_wr_data, lat);
    @(negedge clk);
  endtask

  task automatic test_reg();
    exp_t e;
    int lat;
    int wb;
    poke(1'b0, 8'd5, 8'h33);
    poke(1'b0, 8'd0, 8'h9C);
    poke(1'b1, 8'h33, 8'h00);
    sb.push_back('{addr: 8'h33, data: 8'h9C, lat: 3, name: "reg"});
    wb = n_writes;
    start_op(2'd2, 8'h00, 3'd5);
    n_total++;
    if ({ifc.reg_ry_sel, ifc.reg_read_en, ifc.mar_write_en} !== {3'd5, 2'b11})
      $display("FAIL reg_cycle1: sel/rd/mar=%0d/%b%b want 5/11",
               ifc.reg_ry_sel, ifc.reg_read_en, ifc.mar_write_en);
    else n_pass++;
    wait_done(1, lat);
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat) $display("FAIL %s_latency: got %0d want %0d", e.name, lat, e.lat);
    else n_pass++;
    n_total++;
    if ({last_wr_addr, last_wr_data, mem[e.addr]} !== {e.addr, e.data, e.data})
      $display("FAIL %s_write: addr/data=%02h/%02h want %02h/%02h",
               e.name, last_wr_addr, last_wr_data, e.addr, e.data);
    else n_pass++;
    n_total++;
    if (n_writes - wb !== 1) $display("FAIL %s_write_count: got %0d want 1", e.name, n_writes - wb);
    else n_pass++;
    $display("txn %s addr=%02h data=%02h lat=%0d", e.name, last_wr_addr, last_wr_data, lat);
    @(negedge clk);
  endtask

  task automatic test_reg_ind();
    exp_t e;
    int lat;
    int wb;
    poke(1'b0, 8'd2, 8'hF3);
    poke(1'b0, 8'd3, 8'h40);
    poke(1'b0, 8'd0, 8'h5A);
    poke(1'b1, 8'h40, 8'h00);
    sb.push_back('{addr: 8'h40, data: 8'h5A, lat: 4, name: "reg_ind"});
    wb = n_writes;
    start_op(2'd3, 8'h00, 3'd2);
    n_total++;
    if ({ifc.reg_ry_sel, ifc.reg_read_en, ifc.mar_write_en} !== {3'd2, 2'b10})
      $display("FAIL reg_ind_latch: sel/rd/mar=%0d/%b%b want 2/10",
               ifc.reg_ry_sel, ifc.reg_read_en, ifc.mar_write_en);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({ifc.reg_ry_sel, ifc.reg_read_en, ifc.mar_write_en} !== {3'd3, 2'b11})
      $display("FAIL reg_ind_ptr: sel/rd/mar=%0d/%b%b want 3/11",
               ifc.reg_ry_sel, ifc.reg_read_en, ifc.mar_write_en);
    else n_pass++;
    wait_done(2, lat);
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat) $display("FAIL %s_latency: got %0d want %0d", e.name, lat, e.lat);
    else n_pass++;
    n_total++;
    if ({last_wr_addr, last_wr_data, mem[e.addr]} !== {e.addr, e.data, e.data})
      $display("FAIL %s_write: addr/data=%02h/%02h want %02h/%02h",
               e.name, last_wr_addr, last_wr_data, e.addr, e.data);
    else n_pass++;
    n_total++;
    if (n_writes - wb !== 1) $display("FAIL %s_write_count: got %0d want 1", e.name, n_writes - wb);
    else n_pass++;
    $display("txn %s addr=%02h data=%02h lat=%0d", e.name, last_wr_addr, last_wr_data, lat);
    @(negedge clk);
  endtask

  // start re-pulsed while busy and during DONE must be dropped.
  task automatic test_back_to_back();
    exp_t e;
    int lat;
    int wb;
    poke(1'b0, 8'd0, 8'h77);
    poke(1'b1, 8'h60, 8'h00);
    poke(1'b1, 8'h61, 8'hA5);
    sb.push_back('{addr: 8'h60, data: 8'h77, lat: 3, name: "busy_restart"});
    wb = n_writes;
    start_op(2'd0, 8'h60, 3'd0);
    ifc.start = 1'b1;
    ifc.mode  = 2'd2;
    ifc.ry    = 3'd5;
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done(2, lat);
    e = sb.pop_front();
    n_total++;
    if (lat !== e.lat) $display("FAIL %s_latency: got %0d want %0d", e.name, lat, e.lat);
    else n_pass++;
    n_total++;
    if ({last_wr_addr, last_wr_data} !== {e.addr, e.data})
      $display("FAIL %s_write: addr/data=%02h/%02h want %02h/%02h",
               e.name, last_wr_addr, last_wr_data, e.addr, e.data);
    else n_pass++;
    $display("txn %s addr=%02h data=%02h lat=%0d", e.name, last_wr_addr, last_wr_data, lat);
    // Still in DONE: present a new request that must be ignored.
    ifc.start = 1'b1;
    ifc.mode  = 2'd0;
    ifc.imm   = 8'h61;
    @(negedge clk);
    ifc.start = 1'b0;
    n_total++;
    if (ifc.busy !== 1'b0) $display("FAIL start_in_done: busy=%b want 0", ifc.busy);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_total++;
    if ({ifc.busy, mem[8'h61]} !== {1'b0, 8'hA5} || n_writes - wb !== 1)
      $display("FAIL no_queued_start: busy=%b mem61=%02h writes=%0d want 0/a5/1",
               ifc.busy, mem[8'h61], n_writes - wb);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int wb;
    poke(1'b1, 8'h20, 8'h90);
    poke(1'b0, 8'd0, 8'h12);
    poke(1'b1, 8'h90, 8'hEE);
    wb = n_writes;
    start_op(2'd1, 8'h20, 3'd0);
    ifc.start = 1'b1;  // extra start while busy
    @(negedge clk);
    ifc.start = 1'b0;
    n_total++;
    if (ifc.mem_read_en !== 1'b1) $display("FAIL reset_mid_deref: mem_read_en=%b want 1", ifc.mem_read_en);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (out_vec() !== 18'h0) $display("FAIL reset_mid_async: outputs=%05h want 00000", out_vec());
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_total++;
    if ({ifc.busy, mem[8'h90]} !== {1'b0, 8'hEE} || n_writes !== wb)
      $display("FAIL reset_mid_abandon: busy=%b mem90=%02h writes=%0d want 0/ee/0",
               ifc.busy, mem[8'h90], n_writes - wb);
    else n_pass++;
    $display("txn reset_mid abandoned writes=%0d", n_writes - wb);
  endtask

`ifdef MEM_ACCESS_SEQ_LOAD_EN
  task automatic test_load();
    int lat;
    int wb;
    poke(1'b1, 8'h70, 8'hC3);
    poke(1'b0, 8'd0, 8'h01);
    wb = n_writes;
    ifc.dir = 1'b1;
    start_op(2'd0, 8'h70, 3'd0);
    ifc.dir = 1'b0;
    @(negedge clk);
    n_total++;
    if ({ifc.mem_read_en, ifc.reg_write_en, ifc.mem_write_en, ifc.reg_read_en, ifc.reg_rx_sel} !== {4'b1100, 3'd0})
      $display("FAIL load_phase: rd/rwe/wr/rre/rx=%b%b%b%b/%0d want 1100/0",
               ifc.mem_read_en, ifc.reg_write_en, ifc.mem_write_en, ifc.reg_read_en, ifc.reg_rx_sel);
    else n_pass++;
    wait_done(2, lat);
    n_total++;
    if (lat !== 3) $display("FAIL load_latency: got %0d want 3", lat);
    else n_pass++;
    n_total++;
    if (regs[0] !== 8'hC3 || n_writes !== wb)
      $display("FAIL load_result: r0=%02h writes=%0d want c3/0", regs[0], n_writes - wb);
    else n_pass++;
    $display("txn load addr=70 r0=%02h lat=%0d", regs[0], lat);
    @(negedge clk);
  endtask
`endif

  // ---------------- main ----------------
  initial begin
    int nd;
    ifc.start = 1'b0;
    ifc.mode  = 2'd0;
    ifc.imm   = 8'h00;
    ifc.ry    = 3'd0;
`ifdef MEM_ACCESS_SEQ_LOAD_EN
    ifc.dir   = 1'b0;
`endif

    // Per-cycle bus rules, checked away from the active edge.
    fork
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
          nd = int'(ifc.cu_out_en) + int'(ifc.reg_read_en) + int'(ifc.mem_read_en);
          n_total++;
          if (nd > 1) $display("FAIL bus_drivers: %0d drivers want <=1", nd);
          else n_pass++;
          n_total++;
          if ((!ifc.busy || ifc.done) && (nd != 0 || ifc.mar_write_en || ifc.mem_write_en))
            $display("FAIL idle_quiet: busy/done=%b%b drivers=%0d mar=%b wr=%b want no activity",
                     ifc.busy, ifc.done, nd, ifc.mar_write_en, ifc.mem_write_en);
          else if (ifc.done && !ifc.busy)
            $display("FAIL done_busy: busy=%b want 1 with done", ifc.busy);
          else n_pass++;
          n_total++;
          if (!ifc.cu_out_en && ifc.cu_out_data !== 8'h00)
            $display("FAIL cu_out_zero: data=%02h want 00", ifc.cu_out_data);
          else n_pass++;
        end
      end
    join_none

    test_reset();
    test_imm();
    test_mem_ind();
    test_reg();
    test_reg_ind();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_ACCESS_SEQ_LOAD_EN
    test_load();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
